// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl_if : decode/EX hazard signals and stall/flush controls   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      dec_ins;
   logic             ex_valid;
   logic             ex_is_load;
   logic [4:0]       ex_rd;
   logic             br_taken;
   logic             md_done;
   logic             md_start;
   logic             pc_stall;
   logic             fd_stall;
   logic             dec_flush;
   logic             ex_bubble;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output dec_ins, ex_valid, ex_is_load, ex_rd, br_taken, md_done,
      input  md_start, pc_stall, fd_stall, dec_flush, ex_bubble, stall_cnt, flush_cnt
   );

   modport slave (
      input  dec_ins, ex_valid, ex_is_load, ex_rd, br_taken, md_done,
      output md_start, pc_stall, fd_stall, dec_flush, ex_bubble, stall_cnt, flush_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl : load-use / branch / mul-div hazard sequencer for RV32  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module hazard_ctrl #(
   parameter int FLUSH_CYC = 1,
   parameter int CNT_W     = 16
) (
   input wire           clk,
   input wire           rst,
   hazard_ctrl_if.slave bus
);
   localparam logic [6:0]       c_OP_LUI   = 7'b0110111;
   localparam logic [6:0]       c_OP_AUIPC = 7'b0010111;
   localparam logic [6:0]       c_OP_JAL   = 7'b1101111;
   localparam logic [6:0]       c_OP_R     = 7'b0110011;
   localparam logic [6:0]       c_OP_S     = 7'b0100011;
   localparam logic [6:0]       c_OP_B     = 7'b1100011;
   localparam logic [6:0]       c_F7_MD    = 7'b0000001;
   localparam logic [2:0]       c_FLUSH_RELOAD = 3'(FLUSH_CYC - 1);
   localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_FLUSH   = 2'd1,
      S_MD_WAIT = 2'd2,
      S_MD_DONE = 2'd3
   } t_state;

   t_state           r_state;
   t_state           w_state_nxt;
   logic [2:0]       r_fcnt;
   logic [2:0]       w_fcnt_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic [6:0] w_opcode;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic       w_use_rs1;
   logic       w_use_rs2;
   logic       w_load_use;
   logic       w_muldiv;
   logic       w_unused;

   logic w_md_start;
   logic w_pc_stall;
   logic w_fd_stall;
   logic w_dec_flush;
   logic w_ex_bubble;
   logic w_flush_evt;

   assign w_opcode = bus.dec_ins[6:0];
   assign w_rs1    = bus.dec_ins[19:15];
   assign w_rs2    = bus.dec_ins[24:20];
   assign w_unused = ^bus.dec_ins[14:7];

   assign w_use_rs1 = (w_opcode != c_OP_LUI) && (w_opcode != c_OP_AUIPC) && (w_opcode != c_OP_JAL);
   assign w_use_rs2 = (w_opcode == c_OP_R) || (w_opcode == c_OP_S) || (w_opcode == c_OP_B);
   assign w_muldiv  = (w_opcode == c_OP_R) && (bus.dec_ins[31:25] == c_F7_MD);

   // ex_rd != 0 also covers the "x0 source never hazards" rule
   assign w_load_use = bus.ex_valid && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                       ((w_use_rs1 && (w_rs1 == bus.ex_rd)) ||
                        (w_use_rs2 && (w_rs2 == bus.ex_rd)));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_RUN;
         r_fcnt      <= 3'd0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
         if (w_pc_stall && (r_stall_cnt != c_CNT_MAX))
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
         if (w_flush_evt && (r_flush_cnt != c_CNT_MAX))
            r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      w_md_start  = 1'b0;
      w_pc_stall  = 1'b0;
      w_fd_stall  = 1'b0;
      w_dec_flush = 1'b0;
      w_ex_bubble = 1'b0;
      w_flush_evt = 1'b0;
      if (rst) begin
         case (r_state)
            S_RUN: begin
               if (bus.br_taken) begin
                  w_dec_flush = 1'b1;
                  w_ex_bubble = 1'b1;
                  w_flush_evt = 1'b1;
                  if (FLUSH_CYC > 1) begin
                     w_state_nxt = S_FLUSH;
                     w_fcnt_nxt  = c_FLUSH_RELOAD;
                  end
               end else if (w_load_use) begin
                  w_pc_stall  = 1'b1;
                  w_fd_stall  = 1'b1;
                  w_ex_bubble = 1'b1;
               end else if (w_muldiv) begin
                  w_md_start  = 1'b1;
                  w_pc_stall  = 1'b1;
                  w_fd_stall  = 1'b1;
                  w_ex_bubble = 1'b1;
                  w_state_nxt = S_MD_WAIT;
               end
            end
            S_FLUSH: begin
               w_dec_flush = 1'b1;
               w_ex_bubble = 1'b1;
               if (bus.br_taken) begin
                  w_flush_evt = 1'b1;
                  w_fcnt_nxt  = c_FLUSH_RELOAD;
               end else if (r_fcnt <= 3'd1) begin
                  w_fcnt_nxt  = 3'd0;
                  w_state_nxt = S_RUN;
               end else begin
                  w_fcnt_nxt = r_fcnt - 3'd1;
               end
            end
            S_MD_WAIT: begin
               w_pc_stall  = 1'b1;
               w_fd_stall  = 1'b1;
               w_ex_bubble = 1'b1;
               if (bus.md_done)
                  w_state_nxt = S_MD_DONE;
            end
            // one free cycle lets the mul/div instruction leave decode without relaunching
            default: begin
               w_state_nxt = S_RUN;
            end
         endcase
      end
   end

   assign bus.md_start  = w_md_start;
   assign bus.pc_stall  = w_pc_stall;
   assign bus.fd_stall  = w_fd_stall;
   assign bus.dec_flush = w_dec_flush;
   assign bus.ex_bubble = w_ex_bubble;
   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;
endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the RV32 core, sitting beside the Decode stage. It inspects the instruction held in the decode register and the instruction in EX. It raises stall, bubble and flush controls for three cases: load-use hazards, taken branches, and multi-cycle mul/div operations. Hazards that operand forwarding cannot cover are sequenced here. It also keeps saturating stall and flush event counters for performance debug.

Parameters:
FLUSH_CYC, 1, cycles dec_flush is held after a taken branch (1..7)
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-low reset (0 = reset)
dec_ins  in  32  instruction currently in decode register
ex_valid  in  1  EX stage holds a real (non-bubble) instruction
ex_is_load  in  1  EX instruction is a load
ex_rd  in  5  EX instruction destination register
br_taken  in  1  EX resolved a taken branch/jump this cycle
md_done  in  1  multi-cycle mul/div unit finished (1-cycle pulse)
md_start  out  1  1-cycle pulse launching mul/div unit
pc_stall  out  1  hold PC
fd_stall  out  1  hold decode register
dec_flush  out  1  load NOP (32'h00000013) into decode register
ex_bubble  out  1  load NOP into EX register
stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating
flush_cnt  out  CNT_W  taken-branch events, saturating

Behaviour:
- Reset: while rst=0, every control output is forced to 0, both counters are cleared, and the next state is RUN. This applies from any state, including mid-MD_WAIT; the mul/div unit is reset by its own logic.
- Operand use is decoded from dec_ins[6:0]:
  - rs1 is used unless the opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - rs2 is used only for R 0110011, S 0100011 and B 1100011.
  - A source field equal to x0 never causes a hazard.
- muldiv = (opcode==0110011) && (dec_ins[31:25]==0000001).
- load_use = ex_valid && ex_is_load && ex_rd!=0 && ((use_rs1 && rs1==ex_rd) || (use_rs2 && rs2==ex_rd)).
- FSM states: RUN, FLUSH, MD_WAIT, MD_DONE. Outputs are combinational from state and inputs.
- RUN, checked in priority order:
  1. br_taken: dec_flush=1, ex_bubble=1, flush_cnt+1. If FLUSH_CYC>1, go to FLUSH with a remaining count of FLUSH_CYC-1; otherwise stay in RUN. Load-use and muldiv are ignored this cycle.
  2. load_use: pc_stall=fd_stall=ex_bubble=1. Stay in RUN; the stall clears naturally next cycle because EX then holds a bubble.
  3. muldiv: md_start=1, pc_stall=fd_stall=ex_bubble=1, go to MD_WAIT.
  4. Otherwise all controls are 0.
- FLUSH: dec_flush=1, ex_bubble=1, decrement the count, return to RUN when the count reaches 0. A new br_taken here restarts the count and increments flush_cnt.
- MD_WAIT: pc_stall=fd_stall=ex_bubble=1 and md_start=0. On md_done, go to MD_DONE; the stall is still asserted in the md_done cycle. br_taken is ignored because EX holds only bubbles.
- MD_DONE: exactly one cycle with all controls 0, so the mul/div instruction advances to EX. md_start must not re-fire for that instruction. Return to RUN.
- md_done outside MD_WAIT is ignored.
- stall_cnt increments on every cycle with pc_stall=1. flush_cnt increments once per accepted br_taken. Both hold at 2^CNT_W-1 rather than wrapping.
- Latency: all hazard controls respond in the same cycle as their cause; there are no registered outputs other than the counters.

Test Plan:
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=5, dec_ins=0x00728333 (add x6,x5,x7) -> same cycle pc_stall=fd_stall=ex_bubble=1 and stall_cnt 0->1. Next cycle with ex_valid=0 -> all controls 0.
- No false hazard:
  - ex_rd=0 with dec_ins=0x00100093 -> no stall.
  - ex_rd=5 with dec_ins=0x000280B7 (lui x1, rs1 field=5) -> no stall.
- Mul/div: dec_ins=0x022081B3 (mul x3,x1,x2) in RUN:
  - md_start high for exactly 1 cycle, then stall for 4 cycles until md_done.
  - MD_DONE cycle has all controls 0; no second md_start.
  - stall_cnt=5.
- Branch with FLUSH_CYC=2: br_taken pulse -> dec_flush=ex_bubble=1 for 2 cycles, flush_cnt=1, pc_stall never asserted.
- Simultaneous br_taken and load_use in RUN -> flush only: pc_stall=0 and stall_cnt unchanged.
- Reset during MD_WAIT: rst=0 for 1 cycle -> all outputs 0, counters 0. After rst=1 with a non-hazard dec_ins, state is RUN; a late md_done is ignored.
- Saturation with CNT_W=4: hold load_use for 20 cycles -> stall_cnt stops at 15.
